encoder_8b10b: RTL and testbench

- Transmit-side IEEE 802.3 Clause 36 8B/10B encoder for the PCS.
- Converts one octet per accepted transfer (data or control) into a 10-bit code group and maintains the transmit running disparity (RD).
- Sits between the PCS transmit ordered-set logic and the serializer, with valid/ready handshakes on both sides.
- Its output is the exact code-group format consumed by the receive-side decoder: abcdeifghj, with a = bit 9.

---
 rtl/encoder_8b10b.sv | 161 ++++++++++++++++
 tb/tb_encoder_8b10b.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_8b10b.sv
// Clause 36 8B/10B transmit encoder with running-disparity tracking and a
// single-entry valid/ready output register.
module encoder_8b10b (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] data_in,
    input  logic       is_control_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [9:0] code_group_out,
    output logic       disparity_out,
    output logic       code_err
);

    logic       rd;
    logic [4:0] x;
    logic [2:0] y;
    logic       k_valid;
    logic       is_k28;
    logic [5:0] six_base;
    logic [5:0] six;
    logic       six_neutral;
    logic       rd_mid;
    logic       alt7;
    logic [3:0] four_base;
    logic       four_inv;
    logic [9:0] code;
    logic [3:0] ones;
    logic       rd_next;
    logic       accept;

    // Sub-block tables hold the RD- forms; RD+ forms are their complements.
    function automatic logic [5:0] six_table(input logic [4:0] v);
        unique case (v)
            5'd0:  return 6'b100111;
            5'd1:  return 6'b011101;
            5'd2:  return 6'b101101;
            5'd3:  return 6'b110001;
            5'd4:  return 6'b110101;
            5'd5:  return 6'b101001;
            5'd6:  return 6'b011001;
            5'd7:  return 6'b111000;
            5'd8:  return 6'b111001;
            5'd9:  return 6'b100101;
            5'd10: return 6'b010101;
            5'd11: return 6'b110100;
            5'd12: return 6'b001101;
            5'd13: return 6'b101100;
            5'd14: return 6'b011100;
            5'd15: return 6'b010111;
            5'd16: return 6'b011011;
            5'd17: return 6'b100011;
            5'd18: return 6'b010011;
            5'd19: return 6'b110010;
            5'd20: return 6'b001011;
            5'd21: return 6'b101010;
            5'd22: return 6'b011010;
            5'd23: return 6'b111010;
            5'd24: return 6'b110011;
            5'd25: return 6'b100110;
            5'd26: return 6'b010110;
            5'd27: return 6'b110110;
            5'd28: return 6'b001110;
            5'd29: return 6'b101110;
            5'd30: return 6'b011110;
            5'd31: return 6'b101011;
        endcase
    endfunction

    function automatic logic [3:0] data4_table(input logic [2:0] v);
        unique case (v)
            3'd0: return 4'b1011;
            3'd1: return 4'b1001;
            3'd2: return 4'b0101;
            3'd3: return 4'b1100;
            3'd4: return 4'b1101;
            3'd5: return 4'b1010;
            3'd6: return 4'b0110;
            3'd7: return 4'b1110;
        endcase
    endfunction

    function automatic logic [3:0] k28_table(input logic [2:0] v);
        unique case (v)
            3'd0: return 4'b1011;
            3'd1: return 4'b0110;
            3'd2: return 4'b1010;
            3'd3: return 4'b1100;
            3'd4: return 4'b1101;
            3'd5: return 4'b0101;
            3'd6: return 4'b1001;
            3'd7: return 4'b0111;
        endcase
    endfunction

    function automatic logic [3:0] count_ones(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    assign x        = data_in[4:0];
    assign y        = data_in[7:5];
    assign is_k28   = is_control_in && (x == 5'd28);
    assign k_valid  = is_k28 || (is_control_in && (y == 3'd7) &&
                      ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)));
    assign accept   = in_valid && in_ready;
    assign in_ready = !out_valid || out_ready;

    // Illegal K requests fall through to the Dx.y path because is_k28/k_valid stay low.
    always_comb begin
        six_base    = is_k28 ? 6'b001111 : six_table(x);
        six_neutral = (count_ones({4'b0000, six_base}) == 4'd3);
        six         = (rd && (!six_neutral || (x == 5'd7))) ? ~six_base : six_base;
        rd_mid      = six_neutral ? rd : ~rd;
        alt7        = rd_mid ? ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))
                             : ((x == 5'd17) || (x == 5'd18) || (x == 5'd20));
        four_base   = data4_table(y);
        four_inv    = rd_mid && ((y == 3'd0) || (y == 3'd3) || (y == 3'd4));
        if (is_k28) begin
            four_base = k28_table(y);
            four_inv  = rd_mid;
        end else if (y == 3'd7) begin
            four_base = (k_valid || alt7) ? 4'b0111 : 4'b1110;
            four_inv  = rd_mid;
        end
        code = {six, four_inv ? ~four_base : four_base};
        ones = count_ones(code);
        if (ones > 4'd5) begin
            rd_next = 1'b1;
        end else if (ones < 4'd5) begin
            rd_next = 1'b0;
        end else begin
            rd_next = rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd             <= 1'b0;
            out_valid      <= 1'b0;
            code_group_out <= 10'h000;
            code_err       <= 1'b0;
        end else if (accept) begin
            rd             <= rd_next;
            out_valid      <= 1'b1;
            code_group_out <= code;
            code_err       <= is_control_in && !k_valid;
        end else if (out_ready) begin
            out_valid      <= 1'b0;
        end
    end

    assign disparity_out = rd;

endmodule

// File: tb/tb_encoder_8b10b.sv
// Directed vector table plus hand-written backpressure/reset sequences and a
// randomized stream checked against an explicit-column 8B/10B model.
module tb_encoder_8b10b;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] data_in = 8'h00;
    logic       is_control_in = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [9:0] code_group_out;
    logic       disparity_out;
    logic       code_err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] data;
        logic       ctrl;
        logic [9:0] code;
        logic       rd;
        logic       err;
    } vec_t;

    vec_t vecs[20];

    logic [5:0] six_m [0:31];
    logic [5:0] six_p [0:31];
    logic [3:0] fd_m  [0:7];
    logic [3:0] fd_p  [0:7];
    logic [3:0] k_m   [0:7];
    logic [3:0] k_p   [0:7];
    logic       model_rd;
    logic [10:0] sb[$];

    always #5 clk = ~clk;

    encoder_8b10b dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .data_in(data_in),
        .is_control_in(is_control_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .code_group_out(code_group_out),
        .disparity_out(disparity_out),
        .code_err(code_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_output(input string name, input logic [9:0] exp_code,
                                input logic exp_rd, input logic exp_err);
        check({name, " valid"}, 32'(out_valid), 32'd1);
        check({name, " code"}, 32'(code_group_out), 32'(exp_code));
        check({name, " rd"}, 32'(disparity_out), 32'(exp_rd));
        check({name, " err"}, 32'(code_err), 32'(exp_err));
    endtask

    task automatic apply_stimulus(input logic [7:0] d, input logic k);
        data_in       = d;
        is_control_in = k;
        in_valid      = 1'b1;
    endtask

    // Reference encoder using explicit RD-/RD+ columns and sub-block disparity rules.
    function automatic logic [10:0] model_encode(input logic [7:0] d, input logic k, input logic rd);
        logic [4:0] xx;
        logic [2:0] yy;
        logic [5:0] s;
        logic [3:0] f;
        logic       rd6;
        logic       rd10;
        int         o6;
        int         o4;
        xx = d[4:0];
        yy = d[7:5];
        if (k && xx == 5'd28) s = rd ? 6'b110000 : 6'b001111;
        else                  s = rd ? six_p[xx] : six_m[xx];
        o6  = $countones(s);
        rd6 = (o6 > 3) ? 1'b1 : (o6 < 3) ? 1'b0 : rd;
        if (k && xx == 5'd28) begin
            f = rd6 ? k_p[yy] : k_m[yy];
        end else if (yy == 3'd7 && (k ||
                     (!rd6 && (xx == 5'd17 || xx == 5'd18 || xx == 5'd20)) ||
                     (rd6 && (xx == 5'd11 || xx == 5'd13 || xx == 5'd14)))) begin
            f = rd6 ? 4'b1000 : 4'b0111;
        end else begin
            f = rd6 ? fd_p[yy] : fd_m[yy];
        end
        o4   = $countones(f);
        rd10 = (o4 > 2) ? 1'b1 : (o4 < 2) ? 1'b0 : rd6;
        return {rd10, s, f};
    endfunction

    task automatic pick_octet();
        int r;
        logic [7:0] kx [0:3];
        kx = '{8'hF7, 8'hFB, 8'hFD, 8'hFE};
        if ($urandom_range(0, 7) == 0) begin
            is_control_in = 1'b1;
            r = $urandom_range(0, 11);
            if (r < 8) data_in = {r[2:0], 5'd28};
            else       data_in = kx[r - 8];
        end else begin
            is_control_in = 1'b0;
            data_in       = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic consume_check(input string name);
        logic [10:0] e;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL %s unexpected group actual=%0h expected=none", name, code_group_out);
            end else begin
                e = sb.pop_front();
                check({name, " code"}, 32'(code_group_out), 32'(e[9:0]));
                check({name, " rd"}, 32'(disparity_out), 32'(e[10]));
                check({name, " err"}, 32'(code_err), 32'd0);
            end
        end
    endtask

    task automatic random_phase(input int n);
        logic        pending;
        logic [10:0] m;
        pending = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (!pending) begin
                in_valid = ($urandom_range(0, 3) != 0);
                pick_octet();
                pending = in_valid;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            check("rand in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            consume_check("rand");
            if (in_valid && in_ready) begin
                m        = model_encode(data_in, is_control_in, model_rd);
                model_rd = m[10];
                sb.push_back(m);
                pending  = 1'b0;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        consume_check("drain");
        @(posedge clk);
        #1;
        check("drain out_valid", 32'(out_valid), 32'd0);
        check("drain scoreboard empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [10:0] m;

        six_m = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
                  6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
                  6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                  6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
        six_p = '{6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
                  6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
                  6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
                  6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
        fd_m  = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
        fd_p  = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
        k_m   = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
        k_p   = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};

        // {data, ctrl, code, rd after, err}; RD chains from one row to the next.
        vecs[0]  = '{8'hBC, 1'b1, 10'h0FA, 1'b1, 1'b0};  // K28.5 at RD-
        vecs[1]  = '{8'hBC, 1'b1, 10'h305, 1'b0, 1'b0};  // K28.5 at RD+
        vecs[2]  = '{8'hB5, 1'b0, 10'h2AA, 1'b0, 1'b0};  // D21.5 at RD-
        vecs[3]  = '{8'hBC, 1'b1, 10'h0FA, 1'b1, 1'b0};
        vecs[4]  = '{8'hB5, 1'b0, 10'h2AA, 1'b1, 1'b0};  // D21.5 at RD+
        vecs[5]  = '{8'hF1, 1'b0, 10'h231, 1'b0, 1'b0};  // D17.7 at RD+, P7
        vecs[6]  = '{8'hF1, 1'b0, 10'h237, 1'b1, 1'b0};  // D17.7 at RD-, A7
        vecs[7]  = '{8'hBC, 1'b1, 10'h305, 1'b0, 1'b0};
        vecs[8]  = '{8'h00, 1'b0, 10'h274, 1'b0, 1'b0};  // D0.0 at RD-
        vecs[9]  = '{8'h01, 1'b1, 10'h1D4, 1'b0, 1'b1};  // illegal K1.0
        vecs[10] = '{8'hBC, 1'b1, 10'h0FA, 1'b1, 1'b0};
        vecs[11] = '{8'h1C, 1'b1, 10'h30B, 1'b1, 1'b0};  // K28.0 at RD+
        vecs[12] = '{8'h07, 1'b0, 10'h074, 1'b0, 1'b0};  // D7.0 at RD+
        vecs[13] = '{8'h07, 1'b0, 10'h38B, 1'b1, 1'b0};  // D7.0 at RD-
        vecs[14] = '{8'hF7, 1'b1, 10'h057, 1'b1, 1'b0};  // K23.7 at RD+
        vecs[15] = '{8'hEB, 1'b0, 10'h348, 1'b0, 1'b0};  // D11.7 at RD+, A7
        vecs[16] = '{8'h7F, 1'b0, 10'h2B3, 1'b1, 1'b0};  // D31.3 at RD-
        vecs[17] = '{8'hFC, 1'b1, 10'h307, 1'b1, 1'b0};  // K28.7 at RD+
        vecs[18] = '{8'h3E, 1'b1, 10'h219, 1'b0, 1'b1};  // illegal K30.1 at RD+
        vecs[19] = '{8'hD8, 1'b0, 10'h336, 1'b1, 1'b0};  // D24.6 at RD-

        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset code", 32'(code_group_out), 32'h000);
        check("reset rd", 32'(disparity_out), 32'd0);
        check("reset err", 32'(code_err), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            apply_stimulus(vecs[i].data, vecs[i].ctrl);
            #1;
            if (i == 0) check("first pre-accept out_valid", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
            check_output($sformatf("vec%0d", i), vecs[i].code, vecs[i].rd, vecs[i].err);
        end

        // Backpressure: D24.6 is held while K28.5 waits.
        @(negedge clk);
        out_ready = 1'b0;
        apply_stimulus(8'hBC, 1'b1);
        repeat (3) begin
            #1;
            check("stall in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            check_output("stall hold", 10'h336, 1'b1, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("release in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check_output("after stall", 10'h305, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("no duplicate out_valid", 32'(out_valid), 32'd0);

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        model_rd = 1'b0;
        sb.delete();
        random_phase(400);

        // Mid-stream reset while a group at RD+ is held.
        @(negedge clk);
        out_ready = 1'b0;
        if (model_rd) apply_stimulus(8'hB5, 1'b0);
        else          apply_stimulus(8'hBC, 1'b1);
        m = model_encode(data_in, is_control_in, model_rd);
        @(posedge clk);
        #1;
        check_output("pre-reset held", m[9:0], 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check("midreset code", 32'(code_group_out), 32'h000);
        check("midreset rd", 32'(disparity_out), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        apply_stimulus(8'hBC, 1'b1);
        @(posedge clk);
        #1;
        check_output("post-reset K28.5", 10'h0FA, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        model_rd = 1'b1;
        sb.delete();
        random_phase(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
